div_sequencer: RTL

- Iterative radix-2 restoring divider plus its sequencing FSM for the RV32M DIV/DIVU/REM/REMU group.
- Sits in EX beside the combinational ALU and multiplier. Receives divstart/divctl decoded by the EX controller.
- Stalls the pipeline while a divide is in flight. Presents the result on the done cycle for the EX result mux.

---
 rtl/div_sequencer_pkg.sv | 46 ++++
 rtl/div_sequencer_if.sv | 42 ++++
 rtl/div_sequencer_div_step.sv | 40 ++++
 rtl/div_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_sequencer_pkg
//
// Shared definitions for the iterative RV32M divide unit:
//   - divctl_e     : operation select as produced by the EX controller
//                    (bit 0 = unsigned, bit 1 = remainder)
//   - div_state_e  : sequencing FSM states
//   - DIV_LAT      : start-to-done latency for the default 32-bit datapath
//   - div_latency  : same latency for an arbitrary operand width
//   - ctl_is_signed/ctl_is_rem : decode helpers for divctl
// ---------------------------------------------------------------------------
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIVCTL_DIV  = 2'b00,
    DIVCTL_DIVU = 2'b01,
    DIVCTL_REM  = 2'b10,
    DIVCTL_REMU = 2'b11
  } divctl_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  localparam int XLEN_DEFAULT = 32;

  // Acceptance edge -> PREP -> XLEN CALC cycles -> FIX -> DONE.
  localparam int DIV_LAT = XLEN_DEFAULT + 3;

  function automatic int div_latency(input int xlen);
    return xlen + 3;
  endfunction

  function automatic logic ctl_is_signed(input divctl_e ctl);
    return ~ctl[0];
  endfunction

  function automatic logic ctl_is_rem(input divctl_e ctl);
    return ctl[1];
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// ---------------------------------------------------------------------------
// div_sequencer_if
//
// Request/response bundle between the EX controller and the divide unit.
//   start     : request a divide (controller -> divider)
//   flush     : pipeline kill, aborts any in-flight divide
//   divctl    : operation select (DIV/DIVU/REM/REMU)
//   dividend  : rs1 value, sampled with start
//   divisor   : rs2 value, sampled with start
//   busy      : divider is working (PREP/CALC/FIX)
//   stall     : combinational pipeline hold request
//   done      : one-cycle pulse, result valid
//   result    : quotient or remainder, held until the next done
//
// Modports: master = EX controller side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  import div_sequencer_pkg::*;

  logic            start;
  logic            flush;
  divctl_e         divctl;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, divctl, dividend, divisor,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, flush, divctl, dividend, divisor,
    output busy, stall, done, result
  );

endinterface

// File: rtl/div_sequencer_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//
// One combinational radix-2 restoring division step.
//   rem_in   : partial remainder (must be < divisor for a nonzero divisor)
//   quo_in   : partially formed quotient; its MSB feeds the remainder
//   divisor  : magnitude of the divisor
//   rem_out  : next partial remainder
//   quo_out  : quo_in shifted left with the new quotient bit in the LSB
//
// Kept as its own module so a radix-4 datapath can instantiate two of them.
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;
  logic          borrow;

  // Shifting {rem,quo} left needs one extra bit on the remainder side.
  // Because rem_in < divisor, rem_shift < 2*divisor, so a successful
  // subtraction always leaves diff[XLEN] clear and a failed one always sets
  // it: the top bit of the difference doubles as the borrow flag. With a
  // zero divisor the flag is meaningless, but that case is overridden later.
  always_comb begin
    rem_shift = {rem_in, quo_in[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    borrow    = diff[XLEN];
    rem_out   = borrow ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    quo_out   = {quo_in[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//
// Iterative radix-2 restoring divider with its sequencing FSM for the RV32M
// DIV/DIVU/REM/REMU group. Sits in EX beside the ALU and multiplier, holds
// the pipeline while a divide is in flight and presents a registered result
// on the one-cycle done pulse.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (overrides start and flush)
//   bus  : div_sequencer_if.slave (start/flush/divctl/dividend/divisor in,
//          busy/stall/done/result out)
//
// Parameter:
//   XLEN : operand/result width, power of two, at least 8
//
// Build option:
//   DIV_FASTPATH_EN : when defined, divide-by-zero and signed overflow are
//                     recognised at acceptance and jump straight to FIX,
//                     giving done two cycles after acceptance. Results are
//                     identical with or without it.
// ---------------------------------------------------------------------------
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  div_sequencer_if.slave bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  div_state_e      state_d;
  div_state_e      accept_state;
  logic            accept;
  logic            stall;

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  divctl_e         ctl_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  logic            ctl_signed;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_value;

  // Where an accepted operation goes first. With the fast path, the two
  // RISC-V special cases are spotted on the live operands and skip the
  // iterative loop entirely, since FIX overrides their result anyway.
`ifdef DIV_FASTPATH_EN
  logic special_in;

  assign special_in = (bus.divisor == '0) ||
                      (!bus.divctl[0] && (bus.dividend == SMIN) && (bus.divisor == '1));
  assign accept_state = special_in ? ST_FIX : ST_PREP;
`else
  assign accept_state = ST_PREP;
`endif

  // State register. Reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stall decode. A new op is only accepted from IDLE or
  // DONE (back-to-back), and flush both vetoes acceptance and aborts any
  // in-flight op. stall drops on the done cycle unless a new start arrives,
  // so the pipeline advances and captures the result.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = bus.start;
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_d = accept_state;
        end
      end
      ST_PREP: begin
        stall   = 1'b1;
        state_d = bus.flush ? ST_IDLE : ST_CALC;
      end
      ST_CALC: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        stall   = 1'b1;
        state_d = bus.flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        stall = bus.start;
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          state_d = accept_state;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand magnitudes for the signed ops; unsigned ops pass straight through.
  always_comb begin
    ctl_signed = ctl_is_signed(ctl_q);
    a_abs      = (ctl_signed && a_q[XLEN-1]) ? -a_q : a_q;
    b_abs      = (ctl_signed && b_q[XLEN-1]) ? -b_q : b_q;
  end

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Final correction. The loop works on magnitudes, so the signs are put
  // back here; the quotient takes the XOR of the operand signs and the
  // remainder follows the dividend. The two RISC-V special cases then
  // override whatever the loop produced, which is also what makes the fast
  // path safe to skip PREP/CALC: only the latched operands are consulted.
  always_comb begin
    quo_fix = q_neg_q ? -quo_q : quo_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
    if (b_q == '0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (ctl_signed && (a_q == SMIN) && (b_q == '1)) begin
      quo_fix = a_q;
      rem_fix = '0;
    end
    fix_value = ctl_is_rem(ctl_q) ? rem_fix : quo_fix;
  end

  // Datapath and registered outputs. busy/done are registered from the
  // next state so they line up exactly with PREP..FIX and DONE. Operands
  // are only captured on acceptance, so later changes on the bus are
  // ignored. result is written only by an unflushed FIX and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= DIVCTL_DIV;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_PREP) || (state_d == ST_CALC) || (state_d == ST_FIX);
      done_q <= (state_d == ST_DONE);

      if (accept) begin
        a_q   <= bus.dividend;
        b_q   <= bus.divisor;
        ctl_q <= bus.divctl;
      end

      case (state_q)
        ST_PREP: begin
          quo_q   <= a_abs;
          dvs_q   <= b_abs;
          rem_q   <= '0;
          q_neg_q <= ctl_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          r_neg_q <= ctl_signed & a_q[XLEN-1];
          cnt_q   <= CNT_INIT;
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          if (!bus.flush) begin
            result_q <= fix_value;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = stall;

endmodule
